// File: rtl/spectrum_bar_display_if.sv
// Band-magnitude stream from the FFT band summer: one beat per band, eight beats per frame.
// The master drives the beats and band_last; the slave drives band_ready.
interface spectrum_bar_display_if;
    logic       band_valid;
    logic [7:0] band_data;
    logic       band_last;
    logic       band_ready;

    modport master (
        output band_valid,
        output band_data,
        output band_last,
        input  band_ready
    );

    modport slave (
        input  band_valid,
        input  band_data,
        input  band_last,
        output band_ready
    );
endinterface

// File: rtl/spectrum_bar_display.sv
// Spectrum analyser back end: double-buffered 8-band frame, log2 bars with decaying peak-hold,
// column-scanned 8x8 LED matrix (rows active-low, columns one-hot active-high).
module spectrum_bar_display #(
    parameter int unsigned SCAN_DIV  = 17,
    parameter int unsigned DECAY_DIV = 22
) (
    input  logic                   clkin,
    input  logic                   rst,
    spectrum_bar_display_if.slave  band,
    output logic                   frame_err,
    output logic [7:0]             row,
    output logic [7:0]             column
);

    localparam int unsigned SW = SCAN_DIV + 3;

    typedef enum logic {
        LOAD = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [SW-1:0]        r_scan_cnt;
    logic [DECAY_DIV-1:0] r_decay_cnt;
    logic [2:0]           r_wr_idx;
    logic [7:0]           r_shadow  [8];
    logic [7:0]           r_display [8];
    logic [3:0]           r_peak    [8];
    logic                 r_frame_err;
    logic [7:0]           r_row;
    logic [7:0]           r_column;

    logic       w_ready;
    logic       w_xfer;
    logic       w_frame_done;
    logic       w_err;
    logic       w_commit;
    logic       w_scan_wrap;
    logic       w_decay_tick;
    logic [2:0] w_cc;
    logic [3:0] w_peak_nxt [8];
    logic [3:0] w_h_cc;
    logic [3:0] w_pk_cc;
    logic [7:0] w_row;

    // Bar height: 0 for an empty band, otherwise MSB position plus one (1..8).
    function automatic logic [3:0] height(input logic [7:0] v);
        logic [3:0] h;
        h = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (v[b]) begin
                h = 4'(b + 1);
            end
        end
        return h;
    endfunction

    assign w_scan_wrap  = &r_scan_cnt;
    assign w_decay_tick = &r_decay_cnt;
    assign w_cc         = r_scan_cnt[SW-1:SCAN_DIV];

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PEND doubles as the "pending" flag: a completed frame waits there for the scan boundary.
    always_comb begin
        w_state_nxt  = r_state;
        w_ready      = 1'b0;
        w_xfer       = 1'b0;
        w_frame_done = 1'b0;
        w_err        = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            LOAD: begin
                w_ready = 1'b1;
                w_xfer  = band.band_valid;
                if (w_xfer) begin
                    if (r_wr_idx == 3'd7) begin
                        w_frame_done = 1'b1;
                        w_err        = ~band.band_last;
                        w_state_nxt  = PEND;
                    end else if (band.band_last) begin
                        w_err = 1'b1;
                    end
                end
            end
            PEND: begin
                if (w_scan_wrap) begin
                    w_commit    = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    assign band.band_ready = w_ready;

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_decay_cnt <= '0;
        end else begin
            r_scan_cnt  <= r_scan_cnt + SW'(1);
            r_decay_cnt <= r_decay_cnt + DECAY_DIV'(1);
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_wr_idx    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
            if (w_xfer) begin
                if (w_frame_done || band.band_last) begin
                    r_wr_idx <= '0;
                end else begin
                    r_wr_idx <= r_wr_idx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_xfer) begin
            r_shadow[r_wr_idx] <= band.band_data;
        end
    end

    // On commit the peak sees the incoming frame in the same cycle it lands in display.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            logic [3:0] h_src;
            logic [3:0] dec;
            h_src = height(w_commit ? r_shadow[i] : r_display[i]);
            dec   = (w_decay_tick && (r_peak[i] != 4'd0)) ? (r_peak[i] - 4'd1) : r_peak[i];
            w_peak_nxt[i] = (h_src > dec) ? h_src : dec;
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_display[i] <= '0;
                r_peak[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (w_commit) begin
                    r_display[i] <= r_shadow[i];
                end
                r_peak[i] <= w_peak_nxt[i];
            end
        end
    end

    always_comb begin
        w_h_cc  = height(r_display[w_cc]);
        w_pk_cc = r_peak[w_cc];
        w_row   = '1;
        for (int unsigned m = 0; m < 8; m++) begin
            w_row[m] = ~((4'(m) < w_h_cc) ||
                         ((w_pk_cc != 4'd0) && (4'(m) == (w_pk_cc - 4'd1))));
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_row    <= '1;
            r_column <= 8'h80;
        end else begin
            r_row    <= w_row;
            r_column <= 8'h80 >> w_cc;
        end
    end

    assign frame_err = r_frame_err;
    assign row       = r_row;
    assign column    = r_column;

endmodule

// File: tb/tb_spectrum_bar_display.sv
// Randomized bench for spectrum_bar_display with a frame-level reference model and directed scenarios.
module tb_spectrum_bar_display;

    localparam int SD       = 2;
    localparam int DD       = 6;
    localparam int SCAN_MAX = (1 << (SD + 3)) - 1;
    localparam int DEC_MAX  = (1 << DD) - 1;

    logic       clkin = 1'b0;
    logic       rst;
    logic       frame_err;
    logic [7:0] row;
    logic [7:0] column;

    spectrum_bar_display_if bus ();

    always #5 clkin = ~clkin;

    spectrum_bar_display #(
        .SCAN_DIV  (SD),
        .DECAY_DIV (DD)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .band      (bus.slave),
        .frame_err (frame_err),
        .row       (row),
        .column    (column)
    );

    int m_shadow  [8];
    int m_display [8];
    int m_peak    [8];
    int m_idx;
    bit m_pending;
    int m_scan;
    int m_decay;
    int e_row;
    int e_col;
    int e_err;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hgt(input int v);
        int n = 0;
        while (v > 0) begin
            n++;
            v = v / 2;
        end
        return n;
    endfunction

    function automatic int row_of(input int v, input int pk);
        int lit = (1 << hgt(v)) - 1;
        if (pk != 0) lit = lit | (1 << (pk - 1));
        return (~lit) & 8'hFF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i]  = 0;
            m_display[i] = 0;
            m_peak[i]    = 0;
        end
        m_idx = 0; m_pending = 0; m_scan = 0; m_decay = 0;
        e_row = 8'hFF; e_col = 8'h80; e_err = 0;
    endtask

    // One clock: advance the model on the edge, then compare every output 1 time unit later.
    task automatic step();
        bit xfer, commit, tick;
        int cc, src, d;
        @(posedge clkin);
        if (rst) begin
            model_reset();
        end else begin
            xfer   = bus.band_valid && !m_pending;
            commit = m_pending && (m_scan == SCAN_MAX);
            tick   = (m_decay == DEC_MAX);
            cc     = m_scan / (1 << SD);
            e_col  = 8'h80 >> cc;
            e_row  = row_of(m_display[cc], m_peak[cc]);
            for (int i = 0; i < 8; i++) begin
                src = commit ? m_shadow[i] : m_display[i];
                d   = m_peak[i];
                if (tick && d > 0) d--;
                m_peak[i] = (hgt(src) > d) ? hgt(src) : d;
            end
            if (commit) begin
                for (int i = 0; i < 8; i++) m_display[i] = m_shadow[i];
                m_pending = 0;
            end
            e_err = 0;
            if (xfer) begin
                e_err = ((bus.band_last && m_idx < 7) || (m_idx == 7 && !bus.band_last)) ? 1 : 0;
                m_shadow[m_idx] = bus.band_data;
                if (m_idx == 7) begin
                    m_idx = 0;
                    m_pending = 1;
                end else if (bus.band_last) begin
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            m_scan  = (m_scan + 1) % (SCAN_MAX + 1);
            m_decay = (m_decay + 1) % (DEC_MAX + 1);
        end
        #1;
        check("row", row, e_row);
        check("column", column, e_col);
        check("band_ready", bus.band_ready, m_pending ? 0 : 1);
        check("frame_err", frame_err, e_err);
    endtask

    task automatic idle(input int n);
        bus.band_valid = 1'b0;
        bus.band_last  = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [7:0] f [8], input int last_pos, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            bus.band_valid = 1'b1;
            bus.band_data  = f[k];
            bus.band_last  = (k == last_pos);
            step();
        end
        bus.band_valid = 1'b0;
        bus.band_last  = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.band_ready && n < 200) begin
            step();
            n++;
        end
        if (!bus.band_ready) check("ready_timeout", 0, 1);
    endtask

    function automatic logic [7:0] rnd_mag();
        return 8'($urandom_range(0, 255) >> $urandom_range(0, 8));
    endfunction

    logic [7:0] f2   [8] = '{8'h01, 8'h03, 8'h0F, 8'hFF, 8'h00, 8'h80, 8'h10, 8'h02};
    logic [7:0] r2   [8] = '{8'hFE, 8'hFC, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hE0, 8'hFC};
    logic [7:0] fa   [8];
    logic [7:0] fpk  [8] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] fz   [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        rst = 1'b1;
        bus.band_valid = 1'b0;
        bus.band_data  = '0;
        bus.band_last  = 1'b0;
        model_reset();

        // Reset and free-running column walk
        repeat (3) step();
        check("rst_row", row, 8'hFF);
        check("rst_col", column, 8'h80);
        check("rst_ready", bus.band_ready, 1);
        rst = 1'b0;
        idle(40);

        // Known frame, held in PEND until the boundary, then the fixed row pattern
        send_frame(f2, 7, 8);
        check("pend_ready", bus.band_ready, 0);
        wait_ready();
        step();
        for (int k = 0; k < 8; k++) begin
            check("t2_col", column, 8'h80 >> k);
            check("t2_row", row, r2[k]);
            repeat (4) step();
        end

        // Early band_last drops the partial frame; a full frame then commits
        for (int k = 0; k < 8; k++) fa[k] = rnd_mag();
        send_frame(fa, 3, 4);
        check("drop_err", frame_err, 1);
        idle(2);
        send_frame(fa, 7, 8);
        wait_ready();
        idle(40);

        // Backpressure: valid held high through PEND, first accepted beat is band 0
        for (int k = 0; k < 8; k++) fa[k] = rnd_mag();
        send_frame(fa, 7, 8);
        bus.band_valid = 1'b1;
        bus.band_last  = 1'b0;
        for (int n = 0; n < 200 && !bus.band_ready; n++) begin
            bus.band_data = rnd_mag();
            step();
        end
        for (int k = 0; k < 8; k++) fa[k] = rnd_mag();
        send_frame(fa, 7, 8);
        wait_ready();
        idle(40);

        // Reset mid-frame, then a clean frame
        send_frame(fa, 7, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) fa[k] = rnd_mag();
        send_frame(fa, 7, 8);
        wait_ready();
        idle(40);

        // Peak hold: full band then empty band; marker at level 7 decays away
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        send_frame(fpk, 7, 8);
        wait_ready();
        idle(40);
        send_frame(fz, 7, 8);
        wait_ready();
        step();
        check("peak_col", column, 8'h80);
        check("peak_row", row, 8'h7F);
        idle(600);
        for (int n = 0; n < 16 && column != 8'h80; n++) step();
        check("peak_gone", row, 8'hFF);

        // Random traffic with occasional framing errors and resets
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            bus.band_valid = ($urandom_range(0, 9) < 7);
            bus.band_data  = rnd_mag();
            if (m_idx == 7) bus.band_last = ($urandom_range(0, 7) != 0);
            else            bus.band_last = ($urandom_range(0, 15) == 0);
            step();
        end
        rst = 1'b0;
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
